// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// oversampling ratio used by the receiver and its tick generator.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        idle_s  = 3'd0,
        start_s = 3'd1,
        data_s  = 3'd2,
        stop_s  = 3'd3,
        break_s = 3'd4
    } state_t;

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: a free-running mod-BAUD_DIV counter that
// produces a one-clk pulse on s_tick every BAUD_DIV clocks.
module baud_gen #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider, wraps after BAUD_DIV-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one start bit, DBIT data bits,
// stop bit checked at SB_TICK-1. Bad stop bits raise frame_err and park the
// FSM in break_s until the line returns high, so a held-low line cannot
// spawn phantom frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 27
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            rx_done,
    output logic [DBIT-1:0] rx_data,
    output logic            frame_err
);

    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    // Mid start bit is reached after half a bit period of ticks
    localparam logic [S_W-1:0] MID_START = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] LAST_DATA = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] LAST_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] LAST_BIT  = N_W'(DBIT - 1);

    logic            s_tick;
    logic            rx_meta;
    logic            rx_s;

    state_t          state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] rx_data_d;
    logic            done_d;
    logic            err_d;

    baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (s_tick)
    );

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= idle_s;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            rx_data   <= rx_data_d;
            rx_done   <= done_d;
            frame_err <= err_d;
        end
    end

    // Next-state logic; outputs are decided on the s_tick that samples
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        rx_data_d = rx_data;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            idle_s: begin
                if (!rx_s) begin
                    state_d = start_s;
                    s_d     = '0;
                    n_d     = '0;
                end
            end

            start_s: begin
                if (s_tick) begin
                    if (s_q == MID_START) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_s ? idle_s : data_s;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            data_s: begin
                if (s_tick) begin
                    if (s_q == LAST_DATA) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == LAST_BIT) begin
                            state_d = stop_s;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            stop_s: begin
                if (s_tick) begin
                    if (s_q == LAST_STOP) begin
                        s_d = '0;
                        if (rx_s) begin
                            rx_data_d = b_q;
                            done_d    = 1'b1;
                            state_d   = idle_s;
                        end else begin
                            err_d   = 1'b1;
                            state_d = break_s;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            break_s: begin
                if (rx_s) begin
                    state_d = idle_s;
                    s_d     = '0;
                end
            end

            default: begin
                state_d = idle_s;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

endmodule
